detection_ctrl_17x17: RTL and testbench

Sequencing controller for the 17x17 detection datapath (Haar feature generator, feature BRAM, ANN classifier). For each window it arms and runs feature generation, launches the ANN stage by stage with early reject, and supplies the output-memory address. It also acknowledges the window to the integral-image buffer and reports per-frame status.

---
 rtl/detection_ctrl_17x17.sv | 183 ++++++++++++++++++
 tb/tb_detection_ctrl_17x17.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detection_ctrl_17x17.sv
// detection_ctrl_17x17
// Sequencing controller for the 17x17 face-detection datapath. Walks every
// window of a frame, arms the Haar feature generator once per cascade stage,
// launches the ANN classifier stage by stage with early reject, and reports
// the window index used as the output-memory write address.
// A watchdog bounds every wait on the datapath so a stuck block cannot hang
// the frame: the window is dropped as a reject and a sticky error is raised.

module detection_ctrl_17x17 #(
  parameter int NUM_STAGES = 4,     // cascade stages per window (1..8)
  parameter int NUM_WIN    = 8192,  // windows per frame (1..8192)
  parameter int WDOG_MAX   = 4095   // cycle limit for any datapath wait
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iStart,
  input  logic        iWin_valid,
  input  logic        iFull_FBR,
  input  logic        iFinish_Stage,
  input  logic        iPass,
  output logic        oReady_HFG,
  output logic        oRun_HFG,
  output logic        oRun_ANN,
  output logic [12:0] oAddr_OM,
  output logic [2:0]  oStage,
  output logic        oWin_ack,
  output logic        oFace,
  output logic [12:0] oFace_cnt,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    ARM,
    GEN,
    START_STAGE,
    WAIT_STAGE,
    NEXT,
    DONE
  } state_t;

  localparam logic [12:0] LAST_WIN   = 13'(NUM_WIN - 1);
  localparam logic [2:0]  LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [11:0] WDOG_LIMIT = 12'(WDOG_MAX);
  localparam logic [12:0] FACE_SAT   = 13'h1FFF;

  state_t      stateReg;
  logic [11:0] wdogCntReg;
  logic        wdogExpired;

  // The watchdog counts cycles spent in the current GEN or WAIT_STAGE visit.
  assign wdogExpired = (wdogCntReg == WDOG_LIMIT);

  // Frame sequencer: every output is registered and updated together with
  // the state it belongs to, so each pulse lines up with its state's cycle.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      stateReg   <= IDLE;
      wdogCntReg <= '0;
      oReady_HFG <= 1'b0;
      oRun_HFG   <= 1'b0;
      oRun_ANN   <= 1'b0;
      oAddr_OM   <= '0;
      oStage     <= '0;
      oWin_ack   <= 1'b0;
      oFace      <= 1'b0;
      oFace_cnt  <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      // Single-cycle strobes drop back low unless a transition below re-raises them.
      oReady_HFG <= 1'b0;
      oRun_ANN   <= 1'b0;
      oWin_ack   <= 1'b0;
      oFace      <= 1'b0;
      oDone      <= 1'b0;

      case (stateReg)
        IDLE: begin
          // Frame status stays readable in IDLE until the next frame starts.
          if (iStart) begin
            stateReg  <= WAIT_WIN;
            oBusy     <= 1'b1;
            oAddr_OM  <= '0;
            oStage    <= '0;
            oFace_cnt <= '0;
            oErr      <= 1'b0;
          end
        end

        WAIT_WIN: begin
          if (iWin_valid) begin
            stateReg   <= ARM;
            oReady_HFG <= 1'b1;
          end
        end

        ARM: begin
          stateReg   <= GEN;
          oRun_HFG   <= 1'b1;
          wdogCntReg <= '0;
        end

        GEN: begin
          // A filled feature BRAM takes priority over a watchdog expiry in the same cycle.
          if (iFull_FBR) begin
            stateReg <= START_STAGE;
            oRun_HFG <= 1'b0;
            oRun_ANN <= 1'b1;
          end else if (wdogExpired) begin
            stateReg <= NEXT;
            oRun_HFG <= 1'b0;
            oErr     <= 1'b1;
            oWin_ack <= 1'b1;
          end else begin
            wdogCntReg <= wdogCntReg + 12'd1;
          end
        end

        START_STAGE: begin
          stateReg   <= WAIT_STAGE;
          wdogCntReg <= '0;
        end

        WAIT_STAGE: begin
          // A verdict arriving on the expiry cycle is still honoured.
          if (iFinish_Stage) begin
            if (!iPass) begin
              stateReg <= NEXT;
              oWin_ack <= 1'b1;
            end else if (oStage != LAST_STAGE) begin
              // Each stage uses its own feature set, so regenerate before launching it.
              stateReg   <= ARM;
              oStage     <= oStage + 3'd1;
              oReady_HFG <= 1'b1;
            end else begin
              stateReg <= NEXT;
              oWin_ack <= 1'b1;
              oFace    <= 1'b1;
              if (oFace_cnt != FACE_SAT) begin
                oFace_cnt <= oFace_cnt + 13'd1;
              end
            end
          end else if (wdogExpired) begin
            stateReg <= NEXT;
            oErr     <= 1'b1;
            oWin_ack <= 1'b1;
          end else begin
            wdogCntReg <= wdogCntReg + 12'd1;
          end
        end

        NEXT: begin
          // The address only moves here, after the ANN has finished writing this window.
          if (oAddr_OM == LAST_WIN) begin
            stateReg <= DONE;
            oDone    <= 1'b1;
          end else begin
            stateReg <= WAIT_WIN;
            oAddr_OM <= oAddr_OM + 13'd1;
            oStage   <= '0;
          end
        end

        DONE: begin
          stateReg <= IDLE;
          oBusy    <= 1'b0;
        end

        default: begin
          stateReg <= IDLE;
          oBusy    <= 1'b0;
          oRun_HFG <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detection_ctrl_17x17.sv
// Directed testbench for detection_ctrl_17x17. A small behavioural datapath
// answers the controller (feature BRAM fill after a set delay, stage verdicts
// from a per-window pass mask) and monitors tally the strobes of each frame.

module tb_detection_ctrl_17x17;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic        iReset;
  logic        iStart;
  logic        iWin_valid;
  logic        iFull_FBR = 1'b0;
  logic        iFinish_Stage = 1'b0;
  logic        iPass = 1'b0;
  logic        oReady_HFG, oRun_HFG, oRun_ANN, oWin_ack, oFace, oBusy, oDone, oErr;
  logic [12:0] oAddr_OM, oFace_cnt;
  logic [2:0]  oStage;

  detection_ctrl_17x17 #(.NUM_STAGES(4), .NUM_WIN(3), .WDOG_MAX(15)) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart), .iWin_valid(iWin_valid),
    .iFull_FBR(iFull_FBR), .iFinish_Stage(iFinish_Stage), .iPass(iPass),
    .oReady_HFG(oReady_HFG), .oRun_HFG(oRun_HFG), .oRun_ANN(oRun_ANN),
    .oAddr_OM(oAddr_OM), .oStage(oStage), .oWin_ack(oWin_ack), .oFace(oFace),
    .oFace_cnt(oFace_cnt), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  // Full-size frame with a datapath that answers instantly.
  logic        bigStart;
  logic        bigReady, bigRunHfg, bigRunAnn, bigAck, bigFace, bigBusy, bigDone, bigErr;
  logic [12:0] bigAddr, bigFaceCnt;
  logic [2:0]  bigStage;

  detection_ctrl_17x17 #(.NUM_STAGES(1), .NUM_WIN(8192), .WDOG_MAX(4095)) bigDut (
    .iClk(iClk), .iReset(iReset), .iStart(bigStart), .iWin_valid(1'b1),
    .iFull_FBR(1'b1), .iFinish_Stage(1'b1), .iPass(1'b1),
    .oReady_HFG(bigReady), .oRun_HFG(bigRunHfg), .oRun_ANN(bigRunAnn),
    .oAddr_OM(bigAddr), .oStage(bigStage), .oWin_ack(bigAck), .oFace(bigFace),
    .oFace_cnt(bigFaceCnt), .oBusy(bigBusy), .oDone(bigDone), .oErr(bigErr)
  );

  int checks = 0;
  int errors = 0;

  // Datapath model controls
  int         fullDelay = 2;
  int         finishDelay = 2;
  logic [3:0] passMask [0:3];
  int         genCnt = 0;
  int         annCnt = 0;
  logic       annWait = 1'b0;
  logic       passBit;

  always_comb begin
    passBit = 1'b0;
    if (oAddr_OM < 13'd3) passBit = passMask[oAddr_OM[1:0]][oStage[1:0]];
  end

  // Datapath model: fill the BRAM fullDelay cycles into GEN, give a verdict
  // finishDelay cycles after each ANN launch (fullDelay 0 = never fill).
  always @(negedge iClk) begin
    iFull_FBR     <= 1'b0;
    iFinish_Stage <= 1'b0;
    iPass         <= 1'b0;
    if (oRun_HFG) begin
      genCnt <= genCnt + 1;
      if (fullDelay != 0 && genCnt + 1 == fullDelay) iFull_FBR <= 1'b1;
    end else begin
      genCnt <= 0;
    end
    if (oRun_ANN) begin
      annWait <= 1'b1;
      annCnt  <= 0;
    end else if (annWait) begin
      annCnt <= annCnt + 1;
      if (annCnt + 1 == finishDelay) begin
        iFinish_Stage <= 1'b1;
        iPass         <= passBit;
        annWait       <= 1'b0;
      end
    end
  end

  // Monitor of the small DUT
  int         clearReq = 0, clearSeen = 0;
  int         cyc = 0;
  int         annTotal = 0, facePulses = 0, ackTotal = 0, doneTotal = 0;
  int         annPerWin [0:3];
  logic       ackFace [0:3];
  int         genEntryCyc = -1, errCyc = -1;
  logic       ackAtErr = 1'b0, faceAtErr = 1'b0;
  logic       prevRunHfg = 1'b0, prevErr = 1'b0;
  logic [12:0] addrAtDone = '0;
  logic [2:0]  stageAtLastAck = '0;

  always @(negedge iClk) begin
    cyc        <= cyc + 1;
    prevRunHfg <= oRun_HFG;
    prevErr    <= oErr;
    if (clearReq != clearSeen) begin
      clearSeen   <= clearReq;
      annTotal    <= 0;
      facePulses  <= 0;
      ackTotal    <= 0;
      doneTotal   <= 0;
      genEntryCyc <= -1;
      errCyc      <= -1;
      for (int i = 0; i < 4; i++) begin
        annPerWin[i] <= 0;
        ackFace[i]   <= 1'b0;
      end
    end else begin
      if (oRun_ANN) begin
        annTotal <= annTotal + 1;
        if (oAddr_OM < 13'd4) annPerWin[oAddr_OM[1:0]] <= annPerWin[oAddr_OM[1:0]] + 1;
      end
      if (oFace) facePulses <= facePulses + 1;
      if (oWin_ack) begin
        ackTotal       <= ackTotal + 1;
        stageAtLastAck <= oStage;
        if (oAddr_OM < 13'd4) ackFace[oAddr_OM[1:0]] <= oFace;
      end
      if (oDone) begin
        doneTotal  <= doneTotal + 1;
        addrAtDone <= oAddr_OM;
      end
      if (oRun_HFG && !prevRunHfg && genEntryCyc < 0) genEntryCyc <= cyc;
      if (oErr && !prevErr && errCyc < 0) begin
        errCyc    <= cyc;
        ackAtErr  <= oWin_ack;
        faceAtErr <= oFace;
      end
    end
  end

  // Monitor of the full-size DUT, including a sequential-address model
  int bigAcks = 0, bigFaces = 0, bigDones = 0, bigAddrErrs = 0, bigExpAddr = 0;
  logic [12:0] bigAddrAtDone = '0;

  always @(negedge iClk) begin
    if (bigAck) begin
      bigAcks    <= bigAcks + 1;
      bigExpAddr <= bigExpAddr + 1;
      if (int'(bigAddr) != bigExpAddr) bigAddrErrs <= bigAddrErrs + 1;
    end
    if (bigFace) bigFaces <= bigFaces + 1;
    if (bigDone) begin
      bigDones      <= bigDones + 1;
      bigAddrAtDone <= bigAddr;
    end
  end

  task automatic tick();
    @(negedge iClk);
    #1;
  endtask

  task automatic startFrame();
    clearReq = clearReq + 1;
    tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic waitDone(input int limit, output bit ok);
    int n;
    n = 0;
    while (doneTotal == 0 && n < limit) begin
      tick();
      n++;
    end
    ok = (doneTotal != 0);
  endtask

  task automatic test_reset();
    iReset = 1'b1; iStart = 1'b0; iWin_valid = 1'b0; bigStart = 1'b0;
    for (int i = 0; i < 4; i++) passMask[i] = 4'hF;
    repeat (3) tick();
    checks++;
    if ({oReady_HFG, oRun_HFG, oRun_ANN, oAddr_OM, oStage, oWin_ack, oFace, oFace_cnt, oBusy, oDone, oErr} !== 37'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {oReady_HFG, oRun_HFG, oRun_ANN, oAddr_OM, oStage, oWin_ack, oFace, oFace_cnt, oBusy, oDone, oErr});
    end
    checks++;
    if ({bigReady, bigRunHfg, bigRunAnn, bigAddr, bigStage, bigAck, bigFace, bigFaceCnt, bigBusy, bigDone, bigErr} !== 37'd0) begin
      errors++; $display("FAIL reset_outputs_big: got %h expected 0", {bigReady, bigRunHfg, bigRunAnn, bigAddr, bigStage, bigAck, bigFace, bigFaceCnt, bigBusy, bigDone, bigErr});
    end
    iReset = 1'b0;
    repeat (2) tick();
    checks++;
    if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", oBusy); end
    $display("test_reset done");
  endtask

  task automatic test_all_pass();
    bit ok;
    fullDelay = 5; finishDelay = 3; iWin_valid = 1'b1;
    for (int i = 0; i < 4; i++) passMask[i] = 4'hF;
    startFrame();
    checks++;
    if (oBusy !== 1'b1) begin errors++; $display("FAIL all_pass busy_after_start: got %b expected 1", oBusy); end
    checks++;
    if (oReady_HFG !== 1'b0) begin errors++; $display("FAIL all_pass ready_in_wait_win: got %b expected 0", oReady_HFG); end
    tick();
    checks++;
    if ({oReady_HFG, oRun_HFG} !== 2'b10) begin errors++; $display("FAIL all_pass arm_pulse: got %b expected 10", {oReady_HFG, oRun_HFG}); end
    tick();
    checks++;
    if ({oReady_HFG, oRun_HFG} !== 2'b01) begin errors++; $display("FAIL all_pass gen_run: got %b expected 01", {oReady_HFG, oRun_HFG}); end
    waitDone(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all_pass done_timeout: got no oDone expected one"); end
    checks++;
    if (annTotal !== 12) begin errors++; $display("FAIL all_pass ann_pulses: got %0d expected 12", annTotal); end
    checks++;
    if (facePulses !== 3) begin errors++; $display("FAIL all_pass face_pulses: got %0d expected 3", facePulses); end
    checks++;
    if (ackTotal !== 3) begin errors++; $display("FAIL all_pass win_acks: got %0d expected 3", ackTotal); end
    checks++;
    if (oFace_cnt !== 13'd3) begin errors++; $display("FAIL all_pass face_cnt: got %0d expected 3", oFace_cnt); end
    checks++;
    if (addrAtDone !== 13'd2) begin errors++; $display("FAIL all_pass addr_at_done: got %0d expected 2", addrAtDone); end
    checks++;
    if (stageAtLastAck !== 3'd3) begin errors++; $display("FAIL all_pass stage_at_ack: got %0d expected 3", stageAtLastAck); end
    checks++;
    if (oErr !== 1'b0) begin errors++; $display("FAIL all_pass err: got %b expected 0", oErr); end
    tick();
    checks++;
    if ({oBusy, oDone} !== 2'b00) begin errors++; $display("FAIL all_pass idle_after_done: got %b expected 00", {oBusy, oDone}); end
    tick();
    checks++;
    if (doneTotal !== 1) begin errors++; $display("FAIL all_pass done_count: got %0d expected 1", doneTotal); end
    checks++;
    if (oAddr_OM !== 13'd2) begin errors++; $display("FAIL all_pass addr_hold: got %0d expected 2", oAddr_OM); end
    $display("test_all_pass done");
  endtask

  task automatic test_reject();
    int n;
    bit pulsed;
    fullDelay = 2; finishDelay = 2;
    passMask[0] = 4'b0001; passMask[1] = 4'hF; passMask[2] = 4'hF;
    startFrame();
    n = 0; pulsed = 1'b0;
    // A frame start pulse in the middle of the frame must be ignored.
    while (doneTotal == 0 && n < 3000) begin
      if (!pulsed && oAddr_OM == 13'd1 && oRun_HFG) begin
        iStart = 1'b1; pulsed = 1'b1;
      end else begin
        iStart = 1'b0;
      end
      tick();
      n++;
    end
    iStart = 1'b0;
    checks++;
    if (doneTotal == 0) begin errors++; $display("FAIL reject done_timeout: got no oDone expected one"); end
    checks++;
    if (annPerWin[0] !== 2) begin errors++; $display("FAIL reject ann_win0: got %0d expected 2", annPerWin[0]); end
    checks++;
    if (annPerWin[1] !== 4 || annPerWin[2] !== 4) begin errors++; $display("FAIL reject ann_win12: got %0d/%0d expected 4/4", annPerWin[1], annPerWin[2]); end
    checks++;
    if ({ackFace[0], ackFace[1], ackFace[2]} !== 3'b011) begin errors++; $display("FAIL reject ack_face: got %b expected 011", {ackFace[0], ackFace[1], ackFace[2]}); end
    checks++;
    if (oFace_cnt !== 13'd2) begin errors++; $display("FAIL reject face_cnt: got %0d expected 2", oFace_cnt); end
    checks++;
    if (ackTotal !== 3) begin errors++; $display("FAIL reject win_acks: got %0d expected 3", ackTotal); end
    for (int i = 0; i < 4; i++) passMask[i] = 4'hF;
    $display("test_reject done");
  endtask

  task automatic test_watchdog_gen();
    bit ok;
    fullDelay = 0; finishDelay = 2;
    startFrame();
    waitDone(1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wdog_gen done_timeout: got no oDone expected one"); end
    checks++;
    if (errCyc - genEntryCyc !== 16) begin errors++; $display("FAIL wdog_gen err_latency: got %0d expected 16", errCyc - genEntryCyc); end
    checks++;
    if ({ackAtErr, faceAtErr} !== 2'b10) begin errors++; $display("FAIL wdog_gen ack_with_err: got %b expected 10", {ackAtErr, faceAtErr}); end
    checks++;
    if (annTotal !== 0 || ackTotal !== 3) begin errors++; $display("FAIL wdog_gen counts: got ann=%0d ack=%0d expected ann=0 ack=3", annTotal, ackTotal); end
    tick(); tick();
    checks++;
    if ({oErr, oBusy} !== 2'b10) begin errors++; $display("FAIL wdog_gen err_sticky: got %b expected 10", {oErr, oBusy}); end
    fullDelay = 2;
    startFrame();
    checks++;
    if (oErr !== 1'b0) begin errors++; $display("FAIL wdog_gen err_cleared: got %b expected 0", oErr); end
    waitDone(3000, ok);
    checks++;
    if (!ok || oErr !== 1'b0 || oFace_cnt !== 13'd3) begin errors++; $display("FAIL wdog_gen recover: got done=%b err=%b faces=%0d expected 1/0/3", ok, oErr, oFace_cnt); end
    tick();
    $display("test_watchdog_gen done");
  endtask

  task automatic test_watchdog_stage();
    bit ok;
    fullDelay = 2; finishDelay = 16;
    startFrame();
    waitDone(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wdog_coincident done_timeout: got no oDone expected one"); end
    checks++;
    if (oErr !== 1'b0 || errCyc !== -1) begin errors++; $display("FAIL wdog_coincident err: got %b expected 0", oErr); end
    checks++;
    if (annTotal !== 12 || facePulses !== 3) begin errors++; $display("FAIL wdog_coincident verdicts: got ann=%0d faces=%0d expected 12/3", annTotal, facePulses); end
    tick();
    finishDelay = 17;
    startFrame();
    waitDone(3000, ok);
    checks++;
    if (!ok || oErr !== 1'b1) begin errors++; $display("FAIL wdog_stage expiry: got done=%b err=%b expected 1/1", ok, oErr); end
    checks++;
    if (annTotal !== 3 || facePulses !== 0 || ackTotal !== 3) begin errors++; $display("FAIL wdog_stage counts: got ann=%0d faces=%0d acks=%0d expected 3/0/3", annTotal, facePulses, ackTotal); end
    checks++;
    if (oFace_cnt !== 13'd0) begin errors++; $display("FAIL wdog_stage face_cnt: got %0d expected 0", oFace_cnt); end
    tick();
    finishDelay = 2;
    $display("test_watchdog_stage done");
  endtask

  task automatic test_reset_midframe();
    int n;
    fullDelay = 2; finishDelay = 10;
    startFrame();
    n = 0;
    while (annTotal == 0 && n < 100) begin tick(); n++; end
    checks++;
    if (annTotal == 0) begin errors++; $display("FAIL reset_mid ann_timeout: got no oRun_ANN expected one"); end
    tick(); tick();
    iReset = 1'b1;
    tick();
    checks++;
    if ({oReady_HFG, oRun_HFG, oRun_ANN, oAddr_OM, oStage, oWin_ack, oFace, oFace_cnt, oBusy, oDone, oErr} !== 37'd0) begin
      errors++; $display("FAIL reset_mid outputs: got %h expected 0", {oReady_HFG, oRun_HFG, oRun_ANN, oAddr_OM, oStage, oWin_ack, oFace, oFace_cnt, oBusy, oDone, oErr});
    end
    iReset = 1'b0;
    repeat (15) tick();
    checks++;
    if (oBusy !== 1'b0 || ackTotal !== 0 || doneTotal !== 0) begin errors++; $display("FAIL reset_mid aborted: got busy=%b acks=%0d dones=%0d expected 0/0/0", oBusy, ackTotal, doneTotal); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_back_to_back();
    int n;
    bigStart = 1'b1;
    tick();
    bigStart = 1'b0;
    checks++;
    if (bigBusy !== 1'b1) begin errors++; $display("FAIL full_frame busy: got %b expected 1", bigBusy); end
    n = 0;
    while (bigDones == 0 && n < 60000) begin tick(); n++; end
    checks++;
    if (bigDones == 0) begin errors++; $display("FAIL full_frame done_timeout: got no oDone expected one"); end
    checks++;
    if (bigAcks !== 8192 || bigAddrErrs !== 0) begin errors++; $display("FAIL full_frame acks: got acks=%0d addr_errs=%0d expected 8192/0", bigAcks, bigAddrErrs); end
    checks++;
    if (bigAddrAtDone !== 13'd8191) begin errors++; $display("FAIL full_frame addr_at_done: got %0d expected 8191", bigAddrAtDone); end
    checks++;
    if (bigFaceCnt !== 13'd8191 || bigFaces !== 8192) begin errors++; $display("FAIL full_frame face_sat: got cnt=%0d pulses=%0d expected 8191/8192", bigFaceCnt, bigFaces); end
    repeat (4) tick();
    checks++;
    if (bigDones !== 1 || bigBusy !== 1'b0) begin errors++; $display("FAIL full_frame single_done: got dones=%0d busy=%b expected 1/0", bigDones, bigBusy); end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_reject();
    test_watchdog_gen();
    test_watchdog_stage();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1);
  end

endmodule
